// File: rtl/multicycle_alu_if.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_alu_if
//  Description : Request/response bundle between the EX-stage issue logic
//                and the multi-cycle ALU.
//                  in_valid   - operation request (master -> ALU)
//                  in_ready   - ALU can accept a request this cycle
//                  ALUControl - 4-bit operation code
//                  SrcA/SrcB  - operands; SrcB[SHW-1:0] is the shift amount
//                  out_valid  - one-cycle completion pulse
//                  ALUResult  - registered result, held until next completion
//                  Zero       - ALUResult == 0, registered with ALUResult
//  Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_alu_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      ALUControl;
    logic [XLEN-1:0] SrcA;
    logic [XLEN-1:0] SrcB;
    logic            out_valid;
    logic [XLEN-1:0] ALUResult;
    logic            Zero;

    modport master (
        output in_valid, ALUControl, SrcA, SrcB,
        input  in_ready, out_valid, ALUResult, Zero
    );

    modport slave (
        input  in_valid, ALUControl, SrcA, SrcB,
        output in_ready, out_valid, ALUResult, Zero
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_alu.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_alu
//  Description : EX-stage ALU. Non-shift operations complete in one cycle;
//                SLL/SRL/SRA are performed serially, one bit per cycle.
//  Ports       : clk   - rising-edge clock
//                rst_n - asynchronous active-low reset
//                bus   - multicycle_alu_if.slave (request, operands, result)
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_alu #(
    parameter int XLEN = 32,
    parameter int SHW  = 5
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    multicycle_alu_if.slave bus
);

    localparam logic [3:0] c_op_add  = 4'b0000;
    localparam logic [3:0] c_op_sub  = 4'b0001;
    localparam logic [3:0] c_op_and  = 4'b0010;
    localparam logic [3:0] c_op_or   = 4'b0011;
    localparam logic [3:0] c_op_sll  = 4'b0100;
    localparam logic [3:0] c_op_slt  = 4'b0101;
    localparam logic [3:0] c_op_srl  = 4'b0110;
    localparam logic [3:0] c_op_sra  = 4'b0111;
    localparam logic [3:0] c_op_xor  = 4'b1000;
    localparam logic [3:0] c_op_sltu = 4'b1001;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        K_SLL = 2'd0,
        K_SRL = 2'd1,
        K_SRA = 2'd2
    } shkind_t;

    state_t          state_q,     state_d;
    shkind_t         kind_q,      kind_d;
    logic [XLEN-1:0] shreg_q,     shreg_d;
    logic [SHW-1:0]  cnt_q,       cnt_d;
    logic [XLEN-1:0] result_q,    result_d;
    logic            zero_q,      zero_d;
    logic            out_valid_q, out_valid_d;

    logic            w_accept;
    logic [SHW-1:0]  w_shamt;
    logic            w_is_shift;
    logic [XLEN-1:0] w_single;
    logic [XLEN-1:0] w_step;
    shkind_t         w_kind;

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.ALUResult = result_q;
    assign bus.Zero      = zero_q;

    assign w_accept = bus.in_valid && (state_q == S_IDLE);
    assign w_shamt  = bus.SrcB[SHW-1:0];

    // Single-cycle result. A shift with shamt 0 lands here too and returns
    // SrcA unchanged, so only non-zero shifts ever enter the serial path.
    always_comb begin
        w_single   = '0;
        w_is_shift = 1'b0;
        w_kind     = K_SLL;
        case (bus.ALUControl)
            c_op_add:  w_single = bus.SrcA + bus.SrcB;
            c_op_sub:  w_single = bus.SrcA - bus.SrcB;
            c_op_and:  w_single = bus.SrcA & bus.SrcB;
            c_op_or:   w_single = bus.SrcA | bus.SrcB;
            c_op_xor:  w_single = bus.SrcA ^ bus.SrcB;
            c_op_slt:  w_single = {{(XLEN-1){1'b0}}, ($signed(bus.SrcA) < $signed(bus.SrcB))};
            c_op_sltu: w_single = {{(XLEN-1){1'b0}}, (bus.SrcA < bus.SrcB)};
            c_op_sll: begin
                w_single   = bus.SrcA;
                w_is_shift = 1'b1;
                w_kind     = K_SLL;
            end
            c_op_srl: begin
                w_single   = bus.SrcA;
                w_is_shift = 1'b1;
                w_kind     = K_SRL;
            end
            c_op_sra: begin
                w_single   = bus.SrcA;
                w_is_shift = 1'b1;
                w_kind     = K_SRA;
            end
            default:   w_single = '0;
        endcase
    end

    // One bit position of the serial shifter.
    always_comb begin
        w_step = shreg_q;
        case (kind_q)
            K_SLL:   w_step = {shreg_q[XLEN-2:0], 1'b0};
            K_SRL:   w_step = {1'b0, shreg_q[XLEN-1:1]};
            K_SRA:   w_step = {shreg_q[XLEN-1], shreg_q[XLEN-1:1]};
            default: w_step = shreg_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        zero_d      = zero_q;
        out_valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_is_shift && (w_shamt != '0)) begin
                        shreg_d = bus.SrcA;
                        cnt_d   = w_shamt;
                        kind_d  = w_kind;
                        state_d = S_SHIFT;
                    end else begin
                        result_d    = w_single;
                        zero_d      = (w_single == '0);
                        out_valid_d = 1'b1;
                    end
                end
            end
            S_SHIFT: begin
                shreg_d = w_step;
                cnt_d   = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) begin
                    result_d    = w_step;
                    zero_d      = (w_step == '0);
                    out_valid_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            kind_q      <= K_SLL;
            shreg_q     <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule
`default_nettype wire
